// File: rtl/spi_note_receiver_if.sv
// spi_note_receiver_if: SPI pins plus the note strobe bundle handed to
// voice_controller.
//   slave  : the receiver side (takes SPI pins, drives note fields)
//   master : host / consumer side (drives SPI pins, observes note fields)
interface spi_note_receiver_if;
  logic        i_sclk;
  logic        i_cs_n;
  logic        i_mosi;
  logic        o_miso;
  logic        o_SPI_flag;
  logic        o_SPI_note_status;
  logic [7:0]  o_SPI_voice_index;
  logic [7:0]  o_SPI_velocity;
  logic [31:0] o_SPI_tuning_code;
  logic        o_frame_err;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi,
    output o_miso, o_SPI_flag, o_SPI_note_status, o_SPI_voice_index,
           o_SPI_velocity, o_SPI_tuning_code, o_frame_err
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi,
    input  o_miso, o_SPI_flag, o_SPI_note_status, o_SPI_voice_index,
           o_SPI_velocity, o_SPI_tuning_code, o_frame_err
  );
endinterface

// File: rtl/spi_note_receiver.sv
// spi_note_receiver: SPI mode-0 slave that decodes 56-bit note frames
// {cmd, voice, velocity, tuning[31:0]} into a one-cycle o_SPI_flag strobe
// with registered, held fields. Malformed frames pulse o_frame_err instead.
// Everything runs in i_clk; SPI pins are oversampled through synchronizers.
//   i_clk   : system clock
//   i_reset : asynchronous active-low reset
//   bus     : spi_note_receiver_if.slave (SPI pins + note outputs)
// Optional: define SPI_STATUS_EN to return {last_frame_ok,0,frame_count}
// on o_miso during byte0; otherwise o_miso is tied low.
module spi_note_receiver #(
  parameter int NUM_VOICES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  spi_note_receiver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [55:0]            sh_q, sh_d;
  logic                   flag_q, flag_d;
  logic                   err_q, err_d;
  logic                   status_q, status_d;
  logic [7:0]             vidx_q, vidx_d;
  logic [7:0]             vel_q, vel_d;
  logic [31:0]            tune_q, tune_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, cs_fall, cs_rise, frame_ok;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign frame_ok = (cnt_q == 6'd56) &&
                    (sh_q[55:48] == 8'h90 || sh_q[55:48] == 8'h80) &&
                    (int'(sh_q[47:40]) < NUM_VOICES);

`ifdef SPI_STATUS_EN
  logic       sclk_fall;
  logic [5:0] fcnt_q, fcnt_d;
  logic       last_ok_q, last_ok_d;
  logic [7:0] miso_sr_q, miso_sr_d;
  assign sclk_fall  = ~sclk_s & sclk_prev_q;
  // Status byte only drives the line while byte0 is on the wire.
  assign bus.o_miso = (state_q == SHIFT && cnt_q < 6'd8) ? miso_sr_q[7] : 1'b0;
`else
  assign bus.o_miso = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.i_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    flag_d      = 1'b0;
    err_d       = 1'b0;
    status_d    = status_q;
    vidx_d      = vidx_q;
    vel_d       = vel_q;
    tune_d      = tune_q;
`ifdef SPI_STATUS_EN
    fcnt_d      = fcnt_q;
    last_ok_d   = last_ok_q;
    miso_sr_d   = miso_sr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cs_fall) begin
          state_d = SHIFT;
`ifdef SPI_STATUS_EN
          miso_sr_d = {last_ok_q, 1'b0, fcnt_q};
`endif
        end
      end
      SHIFT: begin
        // cs_n rise wins over a coincident sclk edge
        if (cs_rise) begin
          state_d = CHECK;
        end else begin
          if (sclk_rise) begin
            sh_d = {sh_q[54:0], mosi_s};
            if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
          end
`ifdef SPI_STATUS_EN
          if (sclk_fall) miso_sr_d = {miso_sr_q[6:0], 1'b0};
`endif
        end
      end
      CHECK: begin
        // a cs_n fall seen here is dropped; the host must re-select
        state_d = IDLE;
        if (frame_ok) begin
          flag_d   = 1'b1;
          status_d = (sh_q[55:48] == 8'h90);
          vidx_d   = sh_q[47:40];
          vel_d    = sh_q[39:32];
          tune_d   = sh_q[31:0];
        end else begin
          err_d = 1'b1;
        end
`ifdef SPI_STATUS_EN
        last_ok_d = frame_ok;
        if (frame_ok) fcnt_d = fcnt_q + 6'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // cs_n synchronizer/previous value reset low: a frame already running at
  // reset release produces no falling edge and is ignored until cs_n idles.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
      status_q    <= 1'b0;
      vidx_q      <= '0;
      vel_q       <= '0;
      tune_q      <= '0;
`ifdef SPI_STATUS_EN
      fcnt_q      <= '0;
      last_ok_q   <= 1'b0;
      miso_sr_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
      status_q    <= status_d;
      vidx_q      <= vidx_d;
      vel_q       <= vel_d;
      tune_q      <= tune_d;
`ifdef SPI_STATUS_EN
      fcnt_q      <= fcnt_d;
      last_ok_q   <= last_ok_d;
      miso_sr_q   <= miso_sr_d;
`endif
    end
  end

  assign bus.o_SPI_flag        = flag_q;
  assign bus.o_frame_err       = err_q;
  assign bus.o_SPI_note_status = status_q;
  assign bus.o_SPI_voice_index = vidx_q;
  assign bus.o_SPI_velocity    = vel_q;
  assign bus.o_SPI_tuning_code = tune_q;

endmodule
